instruction_fetch: RTL and testbench

- Multicycle fetch controller sitting directly upstream of the program counter register.
- Takes the current PC value, issues a read to the synchronous instruction memory and holds the returned word for decode until it is acknowledged.
- Drives the program counter's load-enable and next-value inputs, for both sequential advance and taken branches.
- One instruction is in flight at a time; there is no prefetch.

---
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Multicycle instruction fetch controller sitting upstream of the PC register.
// It reads one word at a time from synchronous instruction memory, holds the
// word for decode until acknowledged, and drives the PC load strobe and next
// value for sequential advance or a taken branch. No prefetch.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   pc_cur                current program counter value
//   stall                 suppress the start of a new fetch
//   mem_rd_en, mem_addr   one-cycle read strobe and registered read address
//   mem_rdata, mem_ready  read data and its valid flag
//   instr_out, instr_valid, instr_ack   latched instruction handshake to decode
//   branch_taken, branch_target         single-cycle redirect request
//   pc_en, pc_next        program counter load strobe and load value
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PC_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_next
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] instr_out_d;
  logic              instr_valid_d;
  logic              pc_en_d;
  logic [ADDR_W-1:0] pc_next_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      pc_en       <= 1'b0;
      pc_next     <= '0;
    end else begin
      state_q     <= state_d;
      mem_rd_en   <= mem_rd_en_d;
      mem_addr    <= mem_addr_d;
      instr_out   <= instr_out_d;
      instr_valid <= instr_valid_d;
      pc_en       <= pc_en_d;
      pc_next     <= pc_next_d;
    end
  end

  // Next-state logic; a branch overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      unique case (state_q)
        // A read is outstanding unless it completes in this very cycle.
        S_REQ:   state_d = S_DRAIN;
        S_WAIT:  state_d = mem_ready ? S_IDLE : S_DRAIN;
        S_DRAIN: state_d = mem_ready ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        // pc_en low means the PC has already absorbed the last update.
        S_IDLE:  if (!stall && !pc_en) state_d = S_REQ;
        S_REQ:   state_d = S_WAIT;
        S_WAIT:  if (mem_ready) state_d = S_HOLD;
        S_HOLD:  if (instr_ack) state_d = S_IDLE;
        S_DRAIN: if (mem_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    mem_rd_en_d   = (state_d == S_REQ);
    mem_addr_d    = mem_addr;
    instr_out_d   = instr_out;
    instr_valid_d = instr_valid;
    pc_en_d       = 1'b0;
    pc_next_d     = pc_next;
    if (branch_taken) begin
      pc_en_d       = 1'b1;
      pc_next_d     = branch_target;
      instr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (state_d == S_REQ) mem_addr_d = pc_cur;
        end
        S_WAIT: begin
          if (mem_ready) begin
            instr_out_d   = mem_rdata;
            instr_valid_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ack) begin
            instr_valid_d = 1'b0;
            pc_en_d       = 1'b1;
            // Wraps modulo 2**ADDR_W.
            pc_next_d     = mem_addr + ADDR_W'(PC_STEP);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. A cycle task emulates the PC
// register (loads pc_next after a pc_en cycle) and a memory with a settable
// read latency.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] pc_cur;
  logic        stall;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ack;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        pc_en;
  logic [15:0] pc_next;

  int checks = 0;
  int passed = 0;

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [15:0] mem_word = 16'h0000;

  instruction_fetch #(.ADDR_W(16), .DATA_W(16), .PC_STEP(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .stall         (stall),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .instr_ack     (instr_ack),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_en         (pc_en),
    .pc_next       (pc_next)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    logic        pe;
    logic [15:0] pn;
    logic        rd;
    pe = pc_en;
    pn = pc_next;
    rd = mem_rd_en;
    @(posedge clk);
    #1;
    if (pe) pc_cur = pn;
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word;
      end
    end
    if (rd) begin
      if (mem_lat <= 1) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word;
      end else begin
        mem_cnt = mem_lat - 1;
      end
    end
  endtask

  // Reset for two cycles, then release with the given PC and quiet inputs.
  task automatic do_reset(input logic [15:0] pc);
    reset         = 1'b0;
    mem_cnt       = 0;
    mem_ready     = 1'b0;
    instr_ack     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    stall         = 1'b0;
    tick();
    tick();
    pc_cur = pc;
    reset  = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_rd_en, mem_addr, instr_out, instr_valid, pc_en, pc_next} !== 51'd0) begin
        $display("FAIL reset_outputs: rd=%b addr=%h out=%h valid=%b pc_en=%b pc_next=%h, want all 0",
                 mem_rd_en, mem_addr, instr_out, instr_valid, pc_en, pc_next);
      end else passed++;
    end
  endtask

  // Basic fetch with 1-cycle memory and ack held high.
  task automatic test_basic_fetch();
    pc_cur    = 16'h0000;
    mem_word  = 16'hA5A5;
    mem_lat   = 1;
    instr_ack = 1'b1;
    reset     = 1'b1;                        // cycle 0
    tick();                                  // cycle 1
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0000) begin
      $display("FAIL basic_strobe: rd=%b addr=%h, want 1 0000", mem_rd_en, mem_addr);
    end else passed++;
    tick();                                  // cycle 2
    checks++;
    if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
      $display("FAIL basic_wait: rd=%b valid=%b, want 0 0", mem_rd_en, instr_valid);
    end else passed++;
    tick();                                  // cycle 3
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 16'hA5A5) begin
      $display("FAIL basic_data: valid=%b out=%h, want 1 a5a5", instr_valid, instr_out);
    end else passed++;
    tick();                                  // cycle 4
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 16'h0001 || instr_valid !== 1'b0) begin
      $display("FAIL basic_pc: pc_en=%b pc_next=%h valid=%b, want 1 0001 0",
               pc_en, pc_next, instr_valid);
    end else passed++;
    tick();                                  // cycle 5
    checks++;
    if (pc_en !== 1'b0 || mem_rd_en !== 1'b0) begin
      $display("FAIL basic_gap: pc_en=%b rd=%b, want 0 0", pc_en, mem_rd_en);
    end else passed++;
    instr_ack = 1'b0;
    mem_word  = 16'h5A5A;
    tick();                                  // cycle 6
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0001) begin
      $display("FAIL basic_next_fetch: rd=%b addr=%h, want 1 0001", mem_rd_en, mem_addr);
    end else passed++;
  endtask

  // Continues from the second fetch with ack withheld.
  task automatic test_ack_withheld();
    tick();                                  // WAIT
    tick();                                  // HOLD
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 16'h5A5A || pc_en !== 1'b0 || mem_rd_en !== 1'b0) begin
        $display("FAIL hold_stable[%0d]: valid=%b out=%h pc_en=%b rd=%b, want 1 5a5a 0 0",
                 i, instr_valid, instr_out, pc_en, mem_rd_en);
      end else passed++;
      tick();
    end
    instr_ack = 1'b1;
    tick();
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 16'h0002 || instr_valid !== 1'b0) begin
      $display("FAIL hold_ack: pc_en=%b pc_next=%h valid=%b, want 1 0002 0",
               pc_en, pc_next, instr_valid);
    end else passed++;
    instr_ack = 1'b0;
    tick();
    checks++;
    if (pc_en !== 1'b0) begin
      $display("FAIL hold_single_pulse: pc_en=%b, want 0", pc_en);
    end else passed++;
  endtask

  task automatic test_wrap();
    do_reset(16'hFFFF);
    mem_word  = 16'h0101;
    mem_lat   = 1;
    instr_ack = 1'b1;
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'hFFFF) begin
      $display("FAIL wrap_strobe: rd=%b addr=%h, want 1 ffff", mem_rd_en, mem_addr);
    end else passed++;
    tick();
    tick();
    tick();
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 16'h0000) begin
      $display("FAIL wrap_pc_next: pc_en=%b pc_next=%h, want 1 0000", pc_en, pc_next);
    end else passed++;
    instr_ack = 1'b0;
  endtask

  task automatic test_branch_in_wait();
    do_reset(16'h0020);
    mem_word = 16'h1234;
    mem_lat  = 3;
    tick();                                  // cycle 1 REQ
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0020) begin
      $display("FAIL br_wait_strobe: rd=%b addr=%h, want 1 0020", mem_rd_en, mem_addr);
    end else passed++;
    tick();                                  // cycle 2 WAIT
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    tick();                                  // cycle 3 DRAIN
    branch_taken  = 1'b0;
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 16'h0040 || instr_valid !== 1'b0) begin
      $display("FAIL br_wait_redirect: pc_en=%b pc_next=%h valid=%b, want 1 0040 0",
               pc_en, pc_next, instr_valid);
    end else passed++;
    for (int i = 0; i < 2; i++) begin
      tick();                                // cycles 4 (ready) and 5
      mem_word = 16'hBEEF;
      checks++;
      if (instr_valid !== 1'b0 || instr_out === 16'h1234 || mem_rd_en !== 1'b0) begin
        $display("FAIL br_wait_discard[%0d]: valid=%b out=%h rd=%b, want 0 !1234 0",
                 i, instr_valid, instr_out, mem_rd_en);
      end else passed++;
    end
    tick();                                  // cycle 6
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0040) begin
      $display("FAIL br_wait_refetch: rd=%b addr=%h, want 1 0040", mem_rd_en, mem_addr);
    end else passed++;
  endtask

  task automatic test_branch_vs_ack();
    do_reset(16'h0010);
    mem_word = 16'h7777;
    mem_lat  = 1;
    tick();                                  // REQ
    tick();                                  // WAIT
    tick();                                  // HOLD
    checks++;
    if (instr_valid !== 1'b1 || mem_addr !== 16'h0010) begin
      $display("FAIL br_ack_hold: valid=%b addr=%h, want 1 0010", instr_valid, mem_addr);
    end else passed++;
    instr_ack     = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    tick();
    instr_ack    = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (pc_en !== 1'b1 || pc_next !== 16'h0100 || instr_valid !== 1'b0) begin
      $display("FAIL br_ack_priority: pc_en=%b pc_next=%h valid=%b, want 1 0100 0",
               pc_en, pc_next, instr_valid);
    end else passed++;
    tick();
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0100) begin
      $display("FAIL br_ack_refetch: rd=%b addr=%h, want 1 0100", mem_rd_en, mem_addr);
    end else passed++;
  endtask

  task automatic test_stall_and_async_reset();
    do_reset(16'h0030);
    stall    = 1'b1;
    mem_word = 16'h0F0F;
    mem_lat  = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (mem_rd_en !== 1'b0) begin
        $display("FAIL stall_hold[%0d]: rd=%b, want 0", i, mem_rd_en);
      end else passed++;
    end
    stall = 1'b0;
    tick();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0030) begin
      $display("FAIL stall_release: rd=%b addr=%h, want 1 0030", mem_rd_en, mem_addr);
    end else passed++;
    instr_ack = 1'b1;
    tick();                                  // WAIT
    tick();                                  // HOLD
    tick();                                  // IDLE, pc_en
    instr_ack = 1'b0;
    mem_lat   = 4;
    tick();                                  // IDLE, pc_cur = 0031
    tick();                                  // REQ
    tick();                                  // WAIT
    checks++;
    if (instr_out !== 16'h0F0F || mem_addr !== 16'h0031) begin
      $display("FAIL pre_reset_state: out=%h addr=%h, want 0f0f 0031", instr_out, mem_addr);
    end else passed++;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, mem_addr, instr_out, instr_valid, pc_en, pc_next} !== 51'd0) begin
      $display("FAIL async_reset: rd=%b addr=%h out=%h valid=%b pc_en=%b pc_next=%h, want all 0",
               mem_rd_en, mem_addr, instr_out, instr_valid, pc_en, pc_next);
    end else passed++;
    do_reset(16'h0000);
  endtask

  initial begin
    reset         = 1'b0;
    pc_cur        = 16'h0000;
    stall         = 1'b0;
    mem_rdata     = 16'hDEAD;
    mem_ready     = 1'b0;
    instr_ack     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    test_reset();
    test_basic_fetch();
    test_ack_withheld();
    test_wrap();
    test_branch_in_wait();
    test_branch_vs_ack();
    test_stall_and_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
